// File: rtl/axi_pkg.sv
// Shared AXI4 encodings: response codes, burst types and burst-length helpers.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: resp_t/burst_t/len_t types, RESP_* and BURST_* constants,
//           burst length limits, and a last-beat helper for down-counters.
package axi_pkg;

  typedef logic [1:0] resp_t;
  typedef logic [1:0] burst_t;

  localparam int unsigned LEN_WIDTH       = 8;
  localparam int unsigned MAX_BURST_BEATS = 256;

  typedef logic [LEN_WIDTH-1:0] len_t;

  // Response encodings
  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  // Burst types
  localparam burst_t BURST_FIXED = 2'b00;
  localparam burst_t BURST_INCR  = 2'b01;
  localparam burst_t BURST_WRAP  = 2'b10;

  // A burst counter loaded with axlen and decremented per beat reaches zero
  // on the final beat; keeping the test here keeps every slave consistent.
  function automatic logic is_last_beat(input len_t beats_left);
    return (beats_left == '0);
  endfunction

endpackage

// File: rtl/axi_channel.sv
// Full AXI4 channel bundle (AW, W, B, AR, R) with master and slave views.
// Latency: n/a (wires only).
// Backpressure: plain valid/ready on all five channels.
// Parameters: ADDR_WIDTH, DATA_WIDTH (<= 1024), ID_WIDTH, USER_WIDTH.
// Modports: master (drives requests, accepts responses), slave (reverse).
interface axi_channel #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned USER_WIDTH = 1
);

  // Write address
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic                    aw_lock;
  logic [3:0]              aw_cache;
  logic [2:0]              aw_prot;
  logic [3:0]              aw_qos;
  logic [3:0]              aw_region;
  logic [USER_WIDTH-1:0]   aw_user;
  logic                    aw_valid;
  logic                    aw_ready;

  // Write data
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic [USER_WIDTH-1:0]   w_user;
  logic                    w_valid;
  logic                    w_ready;

  // Write response
  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic [USER_WIDTH-1:0]   b_user;
  logic                    b_valid;
  logic                    b_ready;

  // Read address
  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic                    ar_lock;
  logic [3:0]              ar_cache;
  logic [2:0]              ar_prot;
  logic [3:0]              ar_qos;
  logic [3:0]              ar_region;
  logic [USER_WIDTH-1:0]   ar_user;
  logic                    ar_valid;
  logic                    ar_ready;

  // Read data
  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic [USER_WIDTH-1:0]   r_user;
  logic                    r_valid;
  logic                    r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/axi_error_slave.sv
// AXI4 error slave: terminates every read and write burst with response RESP.
// Latency: every handshake moves the channel FSM on the next cycle; all outputs are state-decoded registers.
// Backpressure: holds B and R beats stable until b_ready / r_ready; one transaction per direction in flight.
// Ports: clk (rising edge), rst (synchronous, active-high), master (axi_channel.slave).
// Parameters: RESP (response code for B and R), R_DATA (constant read data, low DATA_WIDTH bits used).
// Optional: define AXI_ERROR_SLAVE_ASSERT_EN to compile in protocol assertions.
module axi_error_slave
  import axi_pkg::*;
#(
  parameter resp_t         RESP   = RESP_DECERR,
  parameter logic [1023:0] R_DATA = '0
) (
  input  logic       clk,
  input  logic       rst,
  axi_channel.slave  master
);

  localparam int unsigned IW = $bits(master.aw_id);
  localparam int unsigned DW = $bits(master.r_data);

  // ---------------------------------------------------------------------------
  // Write path: accept AW, swallow W beats up to w_last, then issue one B.
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  w_state_e      w_state_q, w_state_d;
  logic [IW-1:0] w_id_q,    w_id_d;
  logic          aw_ready, w_ready, b_valid;

  assign aw_ready = (w_state_q == W_IDLE);
  assign w_ready  = (w_state_q == W_DATA);
  assign b_valid  = (w_state_q == W_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    unique case (w_state_q)
      W_IDLE: begin
        // aw_len is irrelevant: the burst ends on whichever beat carries w_last.
        if (master.aw_valid && aw_ready) begin
          w_state_d = W_DATA;
          w_id_d    = master.aw_id;
        end
      end
      W_DATA: begin
        if (master.w_valid && w_ready && master.w_last) begin
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (master.b_ready) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign master.aw_ready = aw_ready;
  assign master.w_ready  = w_ready;
  assign master.b_valid  = b_valid;
  assign master.b_id     = w_id_q;
  assign master.b_resp   = RESP;
  assign master.b_user   = '0;

  // ---------------------------------------------------------------------------
  // Read path: accept AR, then stream ar_len+1 constant beats.
  // Scoped so the state literal R_DATA does not collide with the parameter.
  // ---------------------------------------------------------------------------
  if (1) begin : g_read_fsm
    typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
    } r_state_e;

    r_state_e      r_state_q, r_state_d;
    logic [IW-1:0] r_id_q,    r_id_d;
    len_t          r_cnt_q,   r_cnt_d;
    logic          ar_ready, r_valid;

    assign ar_ready = (r_state_q == R_IDLE);
    assign r_valid  = (r_state_q == R_DATA);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state_q <= R_IDLE;
        r_id_q    <= '0;
        r_cnt_q   <= '0;
      end else begin
        r_state_q <= r_state_d;
        r_id_q    <= r_id_d;
        r_cnt_q   <= r_cnt_d;
      end
    end

    always_comb begin
      r_state_d = r_state_q;
      r_id_d    = r_id_q;
      r_cnt_d   = r_cnt_q;
      unique case (r_state_q)
        R_IDLE: begin
          if (master.ar_valid && ar_ready) begin
            r_state_d = R_DATA;
            r_id_d    = master.ar_id;
            r_cnt_d   = master.ar_len;
          end
        end
        R_DATA: begin
          // Counter holds beats remaining after the current one, so 8'hFF
          // yields 256 beats without needing a ninth bit.
          if (master.r_ready) begin
            if (is_last_beat(r_cnt_q)) begin
              r_state_d = R_IDLE;
            end else begin
              r_cnt_d = r_cnt_q - 8'd1;
            end
          end
        end
        default: r_state_d = R_IDLE;
      endcase
    end

    assign master.ar_ready = ar_ready;
    assign master.r_valid  = r_valid;
    assign master.r_id     = r_id_q;
    assign master.r_last   = is_last_beat(r_cnt_q);
    assign master.r_resp   = RESP;
    assign master.r_user   = '0;
  end

  assign master.r_data = R_DATA[DW-1:0];

  // Request attributes and write payload carry no meaning for an error slave.
  logic unused_inputs;
  assign unused_inputs = ^{master.aw_addr, master.aw_len, master.aw_size,
                           master.aw_burst, master.aw_lock, master.aw_cache,
                           master.aw_prot, master.aw_qos, master.aw_region,
                           master.aw_user, master.w_data, master.w_strb,
                           master.w_user, master.ar_addr, master.ar_size,
                           master.ar_burst, master.ar_lock, master.ar_cache,
                           master.ar_prot, master.ar_qos, master.ar_region,
                           master.ar_user};

`ifdef AXI_ERROR_SLAVE_ASSERT_EN
  // W beats accepted since the last AW handshake.
  logic [8:0] w_beats_q;

  always_ff @(posedge clk) begin
    if (rst || (master.aw_valid && master.aw_ready)) begin
      w_beats_q <= '0;
    end else if (master.w_valid && master.w_ready) begin
      w_beats_q <= w_beats_q + 9'd1;
    end
  end

  a_aw_hold: assert property (@(posedge clk) disable iff (rst)
    master.aw_valid && !master.aw_ready |=> master.aw_valid
      && $stable(master.aw_id) && $stable(master.aw_len));
  a_w_hold: assert property (@(posedge clk) disable iff (rst)
    master.w_valid && !master.w_ready |=> master.w_valid
      && $stable(master.w_last) && $stable(master.w_data));
  a_ar_hold: assert property (@(posedge clk) disable iff (rst)
    master.ar_valid && !master.ar_ready |=> master.ar_valid
      && $stable(master.ar_id) && $stable(master.ar_len));
  a_b_hold: assert property (@(posedge clk) disable iff (rst)
    master.b_valid && !master.b_ready |=> master.b_valid
      && $stable(master.b_id) && $stable(master.b_resp));
  a_r_hold: assert property (@(posedge clk) disable iff (rst)
    master.r_valid && !master.r_ready |=> master.r_valid
      && $stable(master.r_id) && $stable(master.r_data)
      && $stable(master.r_resp) && $stable(master.r_last));
  // The 256th beat after an AW handshake must carry w_last.
  a_w_last_bound: assert property (@(posedge clk) disable iff (rst)
    master.w_valid && master.w_ready && !master.w_last |-> w_beats_q < 9'd255);
`endif

endmodule

// File: tb/tb_axi_error_slave.sv
module tb_axi_error_slave;

  localparam int IW = 4;
  localparam int DW = 64;
  localparam int UW = 2;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_channel #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW)) bus ();

  axi_error_slave dut (
    .clk    (clk),
    .rst    (rst),
    .master (bus)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [IW-1:0] id;
    logic          last;
  } rbeat_t;

  rbeat_t        rd_q[$];      // R beats still owed by the slave
  logic [IW-1:0] b_q[$];       // B responses still owed
  bit            wr_open = 0;  // AW accepted, waiting for w_last
  logic [IW-1:0] wr_id;

  int n_cmp = 0, n_fail = 0;
  int n_aw = 0, n_ar = 0, n_w = 0, n_rpop = 0;
  int dut_r = 0, dut_rlast = 0, dut_b = 0;
  bit rnd_rdy = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with this cycle's inputs driven; checks outputs,
  // advances the model over the coming posedge, then lands on the next negedge.
  task automatic step();
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    rbeat_t nb;
    if (rnd_rdy) begin
      bus.r_ready = 1'($urandom_range(0, 1));
      bus.b_ready = 1'($urandom_range(0, 1));
    end
    chk("aw_ready", bus.aw_ready, 64'(!wr_open && b_q.size() == 0));
    chk("w_ready",  bus.w_ready,  64'(wr_open));
    chk("b_valid",  bus.b_valid,  64'(b_q.size() != 0));
    chk("ar_ready", bus.ar_ready, 64'(rd_q.size() == 0));
    chk("r_valid",  bus.r_valid,  64'(rd_q.size() != 0));
    if (b_q.size() != 0) begin
      chk("b_id",   bus.b_id,   64'(b_q[0]));
      chk("b_resp", bus.b_resp, 64'd3);
      chk("b_user", bus.b_user, 64'd0);
    end
    if (rd_q.size() != 0) begin
      chk("r_id",   bus.r_id,   64'(rd_q[0].id));
      chk("r_last", bus.r_last, 64'(rd_q[0].last));
      chk("r_data", bus.r_data, 64'd0);
      chk("r_resp", bus.r_resp, 64'd3);
      chk("r_user", bus.r_user, 64'd0);
    end
    if (bus.r_valid === 1'b1 && bus.r_ready) begin
      dut_r++;
      if (bus.r_last === 1'b1) dut_rlast++;
    end
    if (bus.b_valid === 1'b1 && bus.b_ready) dut_b++;

    aw_hs = bus.aw_valid && !wr_open && b_q.size() == 0;
    w_hs  = bus.w_valid && wr_open;
    b_hs  = bus.b_ready && b_q.size() != 0;
    ar_hs = bus.ar_valid && rd_q.size() == 0;
    r_hs  = bus.r_ready && rd_q.size() != 0;

    if (b_hs) void'(b_q.pop_front());
    if (w_hs) begin
      n_w++;
      if (bus.w_last) begin
        wr_open = 0;
        b_q.push_back(wr_id);
      end
    end
    if (aw_hs) begin
      n_aw++;
      wr_open = 1;
      wr_id   = bus.aw_id;
    end
    if (r_hs) begin
      void'(rd_q.pop_front());
      n_rpop++;
    end
    if (ar_hs) begin
      n_ar++;
      for (int i = 0; i <= int'(bus.ar_len); i++) begin
        nb.id   = bus.ar_id;
        nb.last = (i == int'(bus.ar_len));
        rd_q.push_back(nb);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_addr(input bit do_aw, input logic [IW-1:0] awid, input logic [7:0] awlen,
                           input bit do_ar, input logic [IW-1:0] arid, input logic [7:0] arlen);
    int aw0, ar0;
    aw0 = n_aw;
    ar0 = n_ar;
    bus.aw_valid = do_aw; bus.aw_id = awid; bus.aw_len = awlen; bus.aw_addr = $urandom;
    bus.ar_valid = do_ar; bus.ar_id = arid; bus.ar_len = arlen; bus.ar_addr = $urandom;
    for (int t = 0; t < 1200 && (bus.aw_valid || bus.ar_valid); t++) begin
      step();
      if (n_aw != aw0) bus.aw_valid = 1'b0;
      if (n_ar != ar0) bus.ar_valid = 1'b0;
    end
    chk("addr_timeout", 64'({bus.aw_valid, bus.ar_valid}), 64'd0);
    bus.aw_valid = 1'b0;
    bus.ar_valid = 1'b0;
  endtask

  task automatic send_w(input int nb, input bit gaps);
    for (int i = 0; i < nb; i++) begin
      int w0;
      bus.w_valid = 1'b0;
      if (gaps) repeat ($urandom_range(0, 2)) step();
      bus.w_valid = 1'b1;
      bus.w_last  = (i == nb - 1);
      bus.w_data  = {$urandom, $urandom};
      bus.w_strb  = 8'($urandom);
      w0 = n_w;
      for (int t = 0; t < 600 && n_w == w0; t++) step();
      chk("w_timeout", 64'(n_w != w0), 64'd1);
    end
    bus.w_valid = 1'b0;
    bus.w_last  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int t = 0; t < budget && (rd_q.size() != 0 || b_q.size() != 0); t++) step();
    chk("idle_timeout", 64'(rd_q.size() + b_q.size()), 64'd0);
    step();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    bus.aw_valid = 1'b0;
    bus.w_valid  = 1'b0;
    bus.ar_valid = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_b_valid", bus.b_valid, 64'd0);
      chk("rst_r_valid", bus.r_valid, 64'd0);
    end
    chk("rst_b_id", bus.b_id, 64'd0);
    chk("rst_r_id", bus.r_id, 64'd0);
    rd_q.delete();
    b_q.delete();
    wr_open = 0;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, l0, b0;
    bus.aw_valid = 0; bus.aw_id = 0; bus.aw_addr = 0; bus.aw_len = 0; bus.aw_size = 3'd3;
    bus.aw_burst = 2'b01; bus.aw_lock = 0; bus.aw_cache = 0; bus.aw_prot = 0; bus.aw_qos = 0;
    bus.aw_region = 0; bus.aw_user = 0;
    bus.w_valid = 0; bus.w_data = 0; bus.w_strb = 0; bus.w_last = 0; bus.w_user = 0;
    bus.b_ready = 0;
    bus.ar_valid = 0; bus.ar_id = 0; bus.ar_addr = 0; bus.ar_len = 0; bus.ar_size = 3'd3;
    bus.ar_burst = 2'b01; bus.ar_lock = 0; bus.ar_cache = 0; bus.ar_prot = 0; bus.ar_qos = 0;
    bus.ar_region = 0; bus.ar_user = 0;
    bus.r_ready = 0;

    // Reset state
    do_reset(2);
    step();

    // Single-beat write, id 3
    bus.b_ready = 1; bus.r_ready = 1;
    b0 = dut_b;
    send_addr(1, 4'd3, 8'd0, 0, 4'd0, 8'd0);
    send_w(1, 0);
    wait_idle(20);
    repeat (3) step();
    chk("single_b_count", 64'(dut_b - b0), 64'd1);

    // Four-beat read, id 5
    r0 = dut_r; l0 = dut_rlast;
    send_addr(0, 4'd0, 8'd0, 1, 4'd5, 8'd3);
    wait_idle(20);
    chk("rd4_beats", 64'(dut_r - r0), 64'd4);
    chk("rd4_last",  64'(dut_rlast - l0), 64'd1);

    // Single-beat read
    r0 = dut_r; l0 = dut_rlast;
    send_addr(0, 4'd0, 8'd0, 1, 4'd12, 8'd0);
    wait_idle(20);
    chk("rd1_beats", 64'(dut_r - r0), 64'd1);
    chk("rd1_last",  64'(dut_rlast - l0), 64'd1);

    // 256-beat read with random r_ready stalls
    rnd_rdy = 1;
    r0 = dut_r; l0 = dut_rlast;
    send_addr(0, 4'd0, 8'd0, 1, 4'd9, 8'hFF);
    wait_idle(4000);
    chk("rd256_beats", 64'(dut_r - r0), 64'd256);
    chk("rd256_last",  64'(dut_rlast - l0), 64'd1);
    rnd_rdy = 0;

    // Simultaneous AW and AR, two W beats
    bus.b_ready = 1; bus.r_ready = 1;
    r0 = dut_r; b0 = dut_b;
    send_addr(1, 4'hA, 8'd1, 1, 4'h7, 8'd2);
    send_w(2, 0);
    wait_idle(40);
    chk("dual_r_beats", 64'(dut_r - r0), 64'd3);
    chk("dual_b_count", 64'(dut_b - b0), 64'd1);

    // W presented two cycles before AW must wait
    b0 = dut_b;
    bus.w_valid = 1; bus.w_last = 1; bus.w_data = {$urandom, $urandom};
    step();
    step();
    send_addr(1, 4'd9, 8'd0, 0, 4'd0, 8'd0);
    r0 = n_w;
    for (int t = 0; t < 10 && n_w == r0; t++) step();
    chk("early_w_accept", 64'(n_w - r0), 64'd1);
    bus.w_valid = 0; bus.w_last = 0;
    wait_idle(20);
    chk("early_w_b", 64'(dut_b - b0), 64'd1);

    // Reset during beat 2 of an 8-beat read
    r0 = dut_r;
    send_addr(0, 4'd0, 8'd0, 1, 4'd6, 8'd7);
    l0 = n_rpop;
    for (int t = 0; t < 20 && n_rpop == l0; t++) step();
    do_reset(1);
    repeat (4) step();
    chk("rst_mid_beats", 64'(dut_r - r0), 64'd1);

    // Randomized mixed traffic
    rnd_rdy = 1;
    for (int it = 0; it < 30; it++) begin
      logic [IW-1:0] awid, arid;
      logic [7:0]    arl;
      bit            da, dr;
      int            nw;
      awid = IW'($urandom);
      arid = IW'($urandom);
      arl  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      da   = 1'($urandom_range(0, 1));
      dr   = 1'($urandom_range(0, 1));
      if (!da && !dr) dr = 1;
      nw   = $urandom_range(1, 5);
      send_addr(da, awid, 8'($urandom), dr, arid, arl);
      if (da) send_w(nw, 1);
      wait_idle(4000);
    end
    rnd_rdy = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
